// File: rtl/xbuf_pkg.sv
// xbuf_pkg: shared widths, drain FSM encoding and buffer-index helper for xfer_buffer_unit.
package xbuf_pkg;
   localparam int HOST_W = 32;
   localparam int MEM_W = 256;
   localparam int ADDR_W = 32;
   localparam int BUF_WORDS = 1024;
   localparam int NUM_RXBUF = 2;
   localparam int GS_W = 8;
   localparam int BANKS = MEM_W / HOST_W;
   localparam int BEATS_PER_BUF = BUF_WORDS * HOST_W / MEM_W;
   localparam int ROWS = NUM_RXBUF * BUF_WORDS / BANKS;
   localparam int BANK_W = $clog2(BANKS);
   localparam int WORD_W = $clog2(BUF_WORDS);
   localparam int BEAT_W = $clog2(BEATS_PER_BUF);
   localparam int BUF_W = (NUM_RXBUF > 1) ? $clog2(NUM_RXBUF) : 1;
   localparam int ROW_W = $clog2(ROWS);
   typedef enum logic [1:0] {IDLE, XFER, DONE} xfer_state_t;
   function automatic logic [BUF_W-1:0] next_buf(input logic [BUF_W-1:0] b);
      return (b == BUF_W'(NUM_RXBUF - 1)) ? '0 : b + 1'b1;
   endfunction
endpackage

// File: rtl/xbuf_ram.sv
// xbuf_ram: 8-bank staging RAM, per-bank host-word write, full-width registered read.
// HOST_READBACK_EN adds a registered single-word read port for host readback.
module xbuf_ram
   import xbuf_pkg::*;
(
   input  logic              clock,
   input  logic              wr_en,
   input  logic [BANK_W-1:0] wr_bank,
   input  logic [ROW_W-1:0]  wr_row,
   input  logic [HOST_W-1:0] wr_data,
   input  logic [ROW_W-1:0]  rd_row,
   output logic [MEM_W-1:0]  rd_data
`ifdef HOST_READBACK_EN
   ,
   input  logic [ROW_W-1:0]  rb_row,
   input  logic [BANK_W-1:0] rb_bank,
   output logic [HOST_W-1:0] rb_data
`endif
);
`ifdef HOST_READBACK_EN
   logic [HOST_W-1:0] rb_word [BANKS];
   logic [BANK_W-1:0] rb_bank_q;
   always_ff @(posedge clock) rb_bank_q <= rb_bank;
   assign rb_data = rb_word[rb_bank_q];
`endif
   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic [HOST_W-1:0] mem [ROWS];
      logic [HOST_W-1:0] q;
      always_ff @(posedge clock) begin
         if (wr_en && wr_bank == BANK_W'(b)) mem[wr_row] <= wr_data;
         q <= mem[rd_row];
      end
      assign rd_data[b*HOST_W +: HOST_W] = q;
`ifdef HOST_READBACK_EN
      logic [HOST_W-1:0] rq;
      always_ff @(posedge clock) rq <= mem[rb_row];
      assign rb_word[b] = rq;
`endif
   end
endmodule

// File: rtl/xfer_buffer_unit.sv
// xfer_buffer_unit: ping-pong host staging buffers drained to wide memory as 256-bit beats.
// Optional HOST_READBACK_EN: host reads of the oldest full buffer on hostdata_inout.
module xfer_buffer_unit
   import xbuf_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              host_select,
   input  logic              hwrite_enable,
   inout  wire  [HOST_W-1:0] hostdata_inout,
   input  logic              gs_select,
   input  logic              gs_write_enable,
   output logic [GS_W-1:0]   gs_out,
   output logic              gs_out_enable,
   input  logic              xfer_buf_select,
   input  logic              mwrite_enable,
   input  logic [ADDR_W-1:0] tbm_address,
   output logic              xfer_complete,
   output logic              chip_select,
   output logic              write_enable,
   output logic [ADDR_W-1:0] maddress,
   inout  wire  [MEM_W-1:0]  mdata_inout
);
   localparam logic [BEAT_W:0] LAST_CNT = (BEAT_W+1)'(BEATS_PER_BUF);
   xfer_state_t state, state_nxt;
   logic [NUM_RXBUF-1:0] full;
   logic [BUF_W-1:0] fill_buf, drain_buf;
   logic [WORD_W-1:0] fill_ptr;
   logic [BEAT_W:0] rd_cnt;
   logic [ADDR_W-1:0] base;
   logic [MEM_W-1:0] ram_q;
   logic [GS_W-1:0] free_cnt;
   logic host_wr, fill_last, start, last, issue, prime, rvalid;
   assign host_wr = host_select & hwrite_enable & ~full[fill_buf];
   assign fill_last = host_wr && fill_ptr == WORD_W'(BUF_WORDS - 1);
   assign start = state == IDLE && xfer_buf_select && mwrite_enable && full[drain_buf];
   assign last = rvalid && rd_cnt == LAST_CNT;
   // One settle cycle after entry (prime) puts the first beat two edges after the request.
   assign issue = state == XFER && prime && rd_cnt < LAST_CNT;
   assign free_cnt = GS_W'(NUM_RXBUF - $countones(full));
   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nxt;
   always_comb
      state_nxt = state == IDLE ? (start ? XFER : IDLE) : state == XFER ? (last ? DONE : XFER) : IDLE;
   always_comb begin
      chip_select = rvalid;
      write_enable = rvalid;
      xfer_complete = state == DONE;
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         fill_buf <= '0;
         fill_ptr <= '0;
         drain_buf <= '0;
         full <= '0;
         gs_out <= '0;
         gs_out_enable <= 1'b0;
      end else begin
         if (host_wr) fill_ptr <= fill_ptr + 1'b1;
         if (fill_last) fill_buf <= next_buf(fill_buf);
         if (state == DONE) drain_buf <= next_buf(drain_buf);
         full <= (full | ({NUM_RXBUF{fill_last}} & (NUM_RXBUF'(1) << fill_buf)))
               & ~({NUM_RXBUF{state == DONE}} & (NUM_RXBUF'(1) << drain_buf));
         gs_out_enable <= gs_select & gs_write_enable;
         if (gs_select & gs_write_enable) gs_out <= free_cnt;
      end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         base <= '0;
         rd_cnt <= '0;
         maddress <= '0;
         prime <= 1'b0;
         rvalid <= 1'b0;
      end else begin
         if (start) base <= tbm_address;
         if (start) rd_cnt <= '0;
         else if (issue) rd_cnt <= rd_cnt + 1'b1;
         if (issue) maddress <= base + ADDR_W'(rd_cnt);
         prime <= state == XFER;
         rvalid <= issue;
      end
   assign mdata_inout = (chip_select & write_enable) ? ram_q : 'z;
`ifdef HOST_READBACK_EN
   logic [WORD_W-1:0] rd_ptr;
   logic [HOST_W-1:0] rb_data;
   logic rb_valid, host_rd;
   assign host_rd = host_select & ~hwrite_enable;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         rd_ptr <= '0;
         rb_valid <= 1'b0;
      end else begin
         rb_valid <= host_rd;
         if (host_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   assign hostdata_inout = rb_valid ? rb_data : 'z;
`else
   assign hostdata_inout = 'z;
`endif
   xbuf_ram u_ram (
      .clock   (clock),
      .wr_en   (host_wr),
      .wr_bank (fill_ptr[BANK_W-1:0]),
      .wr_row  ({fill_buf, fill_ptr[WORD_W-1:BANK_W]}),
      .wr_data (hostdata_inout),
      .rd_row  ({drain_buf, rd_cnt[BEAT_W-1:0]}),
      .rd_data (ram_q)
`ifdef HOST_READBACK_EN
      ,
      .rb_row  ({drain_buf, rd_ptr[WORD_W-1:BANK_W]}),
      .rb_bank (rd_ptr[BANK_W-1:0]),
      .rb_data (rb_data)
`endif
   );
endmodule

// File: tb/tb_xfer_buffer_unit.sv
// tb_xfer_buffer_unit: randomized scoreboard bench; a word-queue model predicts beats, completes and gs counts.
module tb_xfer_buffer_unit;
   localparam int NB = 2;
   localparam int BW = 1024;
   logic clock = 0, reset = 0;
   logic host_select = 0, hwrite_enable = 0, gs_select = 0, gs_write_enable = 0;
   logic xfer_buf_select = 0, mwrite_enable = 0;
   logic [31:0] tbm_address = 0;
   logic [7:0] gs_out;
   logic gs_out_enable, xfer_complete, chip_select, write_enable;
   logic [31:0] maddress;
   wire [31:0] hostdata_inout;
   wire [255:0] mdata_inout;
   logic h_oe = 0;
   logic [31:0] h_drv = 0;
   assign hostdata_inout = h_oe ? h_drv : 'z;
   pullup (hostdata_inout);
   pullup (mdata_inout);
   xfer_buffer_unit dut (
      .clock(clock), .reset(reset), .host_select(host_select), .hwrite_enable(hwrite_enable),
      .hostdata_inout(hostdata_inout), .gs_select(gs_select), .gs_write_enable(gs_write_enable),
      .gs_out(gs_out), .gs_out_enable(gs_out_enable), .xfer_buf_select(xfer_buf_select),
      .mwrite_enable(mwrite_enable), .tbm_address(tbm_address), .xfer_complete(xfer_complete),
      .chip_select(chip_select), .write_enable(write_enable), .maddress(maddress),
      .mdata_inout(mdata_inout)
   );
   always #5 clock = ~clock;
   int tests = 0, fails = 0;
   typedef struct { bit done; logic [31:0] addr; logic [255:0] data; } exp_t;
   exp_t sbq[$];
   int gsq[$];
   logic [31:0] cur[$];
   logic [31:0] fullw[$];
   int draining = 0, beats_seen = 0, done_seen = 0;
   task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask
   task automatic bad(input string n, input logic [31:0] act);
      tests++;
      fails++;
      $display("FAIL %s: got %0h with nothing expected", n, act);
   endtask
   function automatic int nfull();
      return fullw.size() / BW + draining;
   endfunction
   function automatic void push_drain(input logic [31:0] a);
      for (int k = 0; k < BW / 8; k++) begin
         logic [255:0] d;
         for (int i = 0; i < 8; i++) d[32*i +: 32] = fullw.pop_front();
         sbq.push_back('{1'b0, a + 32'(k), d});
      end
      sbq.push_back('{1'b1, 32'h0, 256'h0});
      draining++;
   endfunction
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset) begin
            if (chip_select) begin
               beats_seen++;
               if (sbq.size() == 0 || sbq[0].done) bad("unexpected_beat", maddress);
               else begin
                  e = sbq.pop_front();
                  chk("beat_addr", maddress, e.addr);
                  chk("beat_data", mdata_inout, e.data);
                  chk("beat_we", write_enable, 1);
               end
            end else chk("mdata_z", mdata_inout, {256{1'b1}});
            if (xfer_complete) begin
               done_seen++;
               if (sbq.size() == 0 || !sbq[0].done) bad("unexpected_complete", 1);
               else begin
                  void'(sbq.pop_front());
                  chk("complete_quiet_bus", chip_select, 0);
               end
            end
            if (gs_out_enable) begin
               if (gsq.size() == 0) bad("unexpected_gs", gs_out);
               else chk("gs_out", gs_out, gsq.pop_front());
            end
         end
      end
   end
   task automatic hw(input logic [31:0] w);
      host_select = 1; hwrite_enable = 1; h_oe = 1; h_drv = w;
      @(posedge clock);
      if (nfull() < NB) begin
         cur.push_back(w);
         if (cur.size() == BW) begin
            foreach (cur[i]) fullw.push_back(cur[i]);
            cur.delete();
         end
      end
      #1 host_select = 0; hwrite_enable = 0; h_oe = 0;
   endtask
   task automatic fill(input int n);
      for (int i = 0; i < n; i++) hw($urandom);
   endtask
   task automatic gs_q();
      gs_select = 1; gs_write_enable = 1;
      @(posedge clock);
      gsq.push_back(NB - nfull());
      #1 gs_select = 0; gs_write_enable = 0;
   endtask
   task automatic req(input logic [31:0] a, input bit lat);
      xfer_buf_select = 1; mwrite_enable = 1; tbm_address = a;
      @(posedge clock);
      if (fullw.size() >= BW) push_drain(a);
      #1 xfer_buf_select = 0; mwrite_enable = 0; tbm_address = $urandom;
      if (lat) begin
         @(negedge clock) chk("lat_cycle0", chip_select, 0);
         @(negedge clock) chk("lat_cycle1", chip_select, 0);
         @(negedge clock) chk("lat_cycle2", chip_select, 1);
      end
   endtask
   task automatic wait_done(input bit gs_at_done);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!xfer_complete && n < 400);
      if (!xfer_complete) bad("xfer_timeout", n);
      else begin
         if (gs_at_done) begin gs_select = 1; gs_write_enable = 1; end
         @(posedge clock);
         if (gs_at_done) gsq.push_back(NB - nfull());
         draining--;
         #1 gs_select = 0; gs_write_enable = 0;
      end
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int b0, d0, n;
      logic [31:0] a;
      repeat (3) @(posedge clock);
      @(negedge clock) reset = 1;
      @(negedge clock);
      chk("rst_cs", chip_select, 0);
      chk("rst_we", write_enable, 0);
      chk("rst_maddr", maddress, 0);
      chk("rst_gs_out", gs_out, 0);
      chk("rst_gs_en", gs_out_enable, 0);
      chk("rst_complete", xfer_complete, 0);
      chk("rst_mdata_z", mdata_inout, {256{1'b1}});
      chk("rst_host_z", hostdata_inout, 32'hffff_ffff);
      gs_q();
      fill(BW);
      gs_q();
      req(0, 1);
      fill(100);
      wait_done(1);
      gs_q();
      fill(BW - 100 + BW);
      gs_q();
      hw($urandom);
      gs_q();
      a = $urandom;
      xfer_buf_select = 1; mwrite_enable = 1; tbm_address = a;
      @(posedge clock);
      push_drain(a);
      push_drain(a);
      wait_done(0);
      @(posedge clock);
      #1 xfer_buf_select = 0; mwrite_enable = 0;
      wait_done(1);
      gs_q();
      b0 = beats_seen; d0 = done_seen;
      xfer_buf_select = 1; mwrite_enable = 1; tbm_address = $urandom;
      repeat (8) @(posedge clock);
      #1 xfer_buf_select = 0; mwrite_enable = 0;
      repeat (4) @(negedge clock);
      chk("nofull_beats", beats_seen, b0);
      chk("nofull_complete", done_seen, d0);
      fill(BW);
      req($urandom, 0);
      b0 = beats_seen; n = 0;
      while (beats_seen - b0 < 50 && n < 300) begin
         @(posedge clock);
         n++;
      end
      if (beats_seen - b0 < 50) bad("beat50_timeout", n);
      #2 reset = 0;
      #1;
      chk("midrst_cs", chip_select, 0);
      chk("midrst_mdata_z", mdata_inout, {256{1'b1}});
      chk("midrst_complete", xfer_complete, 0);
      sbq.delete(); gsq.delete(); cur.delete(); fullw.delete(); draining = 0;
      repeat (2) @(posedge clock);
      @(negedge clock) reset = 1;
      @(negedge clock) chk("post_rst_maddr", maddress, 0);
      gs_q();
      fill(BW);
`ifdef HOST_READBACK_EN
      @(negedge clock);
      host_select = 1; hwrite_enable = 0; h_oe = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clock);
         @(negedge clock) chk("readback", hostdata_inout, fullw[i]);
      end
      host_select = 0;
`endif
      req($urandom, 1);
      wait_done(0);
      gs_q();
      repeat (5) @(negedge clock);
      chk("sb_drained", sbq.size(), 0);
      chk("gs_drained", gsq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
